// File: rtl/mul_sched.sv
// Two-requester scheduler for one shared external multiplier: operand register (S1)
// feeding per-requester result holding registers (S2). Define MUL_SCHED_RR_EN for round-robin tie-break.
module mul_sched #(
  parameter int OP_W = 10,
  parameter int P_W  = 2*OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid0,
  input  logic            in_valid1,
  output logic            in_ready0,
  output logic            in_ready1,
  input  logic [OP_W-1:0] in_a0,
  input  logic [OP_W-1:0] in_b0,
  input  logic [OP_W-1:0] in_a1,
  input  logic [OP_W-1:0] in_b1,
  output logic [OP_W-1:0] mul_a,
  output logic [OP_W-1:0] mul_b,
  input  logic [P_W-1:0]  mul_p,
  output logic            out_valid0,
  output logic            out_valid1,
  input  logic            out_ready0,
  input  logic            out_ready1,
  output logic [P_W-1:0]  out_p0,
  output logic [P_W-1:0]  out_p1,
  output logic            busy,
  output logic [15:0]     ops_done
);

  logic s1_valid;
  logic s1_id;
  logic elig0, elig1, req0, req1, win, grant;
  logic hs0, hs1, ld0, ld1;

`ifdef MUL_SCHED_RR_EN
  logic prio;  // requester favoured on the next tie
`endif

  always_comb begin
    elig0 = !((s1_valid && !s1_id) || (out_valid0 && !out_ready0));
    elig1 = !((s1_valid &&  s1_id) || (out_valid1 && !out_ready1));
    req0  = in_valid0 && elig0;
    req1  = in_valid1 && elig1;
`ifdef MUL_SCHED_RR_EN
    win   = (req0 && req1) ? prio : req1;
`else
    win   = !req0 && req1;
`endif
    in_ready0 = rst_n && req0 && !win;
    in_ready1 = rst_n && req1 &&  win;
    grant     = in_ready0 || in_ready1;
  end

  assign hs0  = out_valid0 && out_ready0;
  assign hs1  = out_valid1 && out_ready1;
  assign ld0  = s1_valid && !s1_id;
  assign ld1  = s1_valid &&  s1_id;
  assign busy = s1_valid || out_valid0 || out_valid1;

  // S1: operands are held when idle so the multiplier inputs do not toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else if (grant) begin
      s1_valid <= 1'b1;
      s1_id    <= win;
      mul_a    <= win ? in_a1 : in_a0;
      mul_b    <= win ? in_b1 : in_b0;
    end else begin
      s1_valid <= 1'b0;
    end
  end

`ifdef MUL_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     prio <= 1'b0;
    else if (grant) prio <= ~win;
  end
`endif

  // S2: a load wins over a same-cycle drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid0 <= 1'b0;
      out_valid1 <= 1'b0;
      out_p0     <= '0;
      out_p1     <= '0;
      ops_done   <= '0;
    end else begin
      if (ld0) begin
        out_valid0 <= 1'b1;
        out_p0     <= mul_p;
      end else if (hs0) begin
        out_valid0 <= 1'b0;
      end
      if (ld1) begin
        out_valid1 <= 1'b1;
        out_p1     <= mul_p;
      end else if (hs1) begin
        out_valid1 <= 1'b0;
      end
      ops_done <= ops_done + 16'(hs0) + 16'(hs1);
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: directed scenarios plus a randomized run
// against a transaction-level model of the scheduler's rules.
module tb_mul_sched;
  localparam int OP_W = 10;
  localparam int P_W  = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid0 = 0, in_valid1 = 0;
  logic            in_ready0, in_ready1;
  logic [OP_W-1:0] in_a0 = 0, in_b0 = 0, in_a1 = 0, in_b1 = 0;
  logic [OP_W-1:0] mul_a, mul_b;
  logic [P_W-1:0]  mul_p;
  logic            out_valid0, out_valid1;
  logic            out_ready0 = 0, out_ready1 = 0;
  logic [P_W-1:0]  out_p0, out_p1;
  logic            busy;
  logic [15:0]     ops_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // the shared multiplier lives outside the scheduler
  assign mul_p = P_W'(mul_a) * P_W'(mul_b);

  mul_sched #(.OP_W(OP_W), .P_W(P_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_ready0(in_ready0), .in_ready1(in_ready1),
    .in_a0(in_a0), .in_b0(in_b0), .in_a1(in_a1), .in_b1(in_b1),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_ready0(out_ready0), .out_ready1(out_ready1),
    .out_p0(out_p0), .out_p1(out_p1),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid0 = 0; in_valid1 = 0; out_ready0 = 0; out_ready1 = 0;
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_valid0 = 1; in_valid1 = 1;
    #1;
    checks++;
    if ({in_ready0, in_ready1} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b want=00", {in_ready0, in_ready1});
    end
    checks++;
    if ({out_valid0, out_valid1, busy, ops_done, mul_a, mul_b, out_p0, out_p1} !== '0) begin
      failures++; $display("FAIL reset_state ov=%b%b busy=%b ops=%0d a=%0d b=%0d want all zero",
                           out_valid0, out_valid1, busy, ops_done, mul_a, mul_b);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    in_a0 = 10'd1023; in_b0 = 10'd1023; in_valid0 = 1; out_ready0 = 1;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin failures++; $display("FAIL single_ready got=%b want=1", in_ready0); end
    cyc(); in_valid0 = 0; #1;
    checks++;
    if (mul_a !== 10'd1023 || mul_b !== 10'd1023 || out_valid0 !== 1'b0) begin
      failures++; $display("FAIL single_t1 a=%0d b=%0d ov=%b want 1023 1023 0", mul_a, mul_b, out_valid0);
    end
    cyc(); #1;
    checks++;
    if (out_valid0 !== 1'b1 || out_p0 !== 20'd1046529) begin
      failures++; $display("FAIL single_t2 ov=%b p=%0d want 1 1046529", out_valid0, out_p0);
    end
    cyc(); #1;
    checks++;
    if (ops_done !== 16'd1 || out_valid0 !== 1'b0) begin
      failures++; $display("FAIL single_done ops=%0d ov=%b want 1 0", ops_done, out_valid0);
    end
  endtask

  task automatic test_contention();
    int g;
    do_reset();
    out_ready0 = 1; out_ready1 = 1;
    in_valid0 = 1; in_valid1 = 1;
    for (int k = 0; k < 6; k++) begin
      in_a0 = 10'($urandom); in_b0 = 10'($urandom);
      in_a1 = 10'($urandom); in_b1 = 10'($urandom);
      #1;
      g = in_ready1 ? 1 : (in_ready0 ? 0 : 2);
      checks++;
      if (g !== k % 2 || (in_ready0 && in_ready1)) begin
        failures++; $display("FAIL contention_grant k=%0d got=%0d want=%0d", k, g, k % 2);
      end
      cyc();
    end
    // tie right after requester 0 was served: round-robin hands it to 1
    do_reset();
    out_ready0 = 1; out_ready1 = 1;
    in_valid0 = 1; #1; cyc();
    in_valid0 = 0; cyc(); cyc();
    in_valid0 = 1; in_valid1 = 1; #1;
    checks++;
`ifdef MUL_SCHED_RR_EN
    if ({in_ready1, in_ready0} !== 2'b10) begin
`else
    if ({in_ready1, in_ready0} !== 2'b01) begin
`endif
      failures++; $display("FAIL tie_break got r1r0=%b%b", in_ready1, in_ready0);
    end
    cyc();
    in_valid0 = 0; in_valid1 = 0;
    cyc(); cyc();
  endtask

  task automatic test_backpressure();
    logic [P_W-1:0] held;
    int acc0;
    do_reset();
    out_ready0 = 1; out_ready1 = 0;
    in_a1 = 10'($urandom); in_b1 = 10'($urandom);
    held = P_W'(in_a1) * P_W'(in_b1);
    in_valid1 = 1; #1;
    checks++;
    if (in_ready1 !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b want=1", in_ready1); end
    cyc(); #1;
    checks++;
    if (in_ready1 !== 1'b0) begin failures++; $display("FAIL bp_s1_block got=%b want=0", in_ready1); end
    cyc();
    acc0 = 0;
    in_valid0 = 1;
    for (int k = 0; k < 6; k++) begin
      in_a0 = 10'($urandom); in_b0 = 10'($urandom);
      #1;
      checks++;
      if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_p1 !== held) begin
        failures++; $display("FAIL bp_hold k=%0d r1=%b ov1=%b p1=%0d want 0 1 %0d", k, in_ready1, out_valid1, out_p1, held);
      end
      if (in_ready0) acc0++;
      cyc();
    end
    checks++;
    if (acc0 !== 3) begin failures++; $display("FAIL bp_port0_served got=%0d want=3", acc0); end
    in_valid0 = 0; in_valid1 = 0; out_ready1 = 1;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    logic [P_W-1:0] q[$];
    logic [P_W-1:0] e;
    int delivered;
    do_reset();
    out_ready0 = 1; delivered = 0;
    in_a0 = 10'($urandom); in_b0 = 10'($urandom);
    for (int c = 0; c < 15; c++) begin
      in_valid0 = (c < 12);
      #1;
      if (out_valid0 && out_ready0) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        delivered++;
        checks++;
        if (out_p0 !== e) begin failures++; $display("FAIL b2b_data c=%0d got=%0d want=%0d", c, out_p0, e); end
      end
      if (in_valid0 && in_ready0) q.push_back(P_W'(in_a0) * P_W'(in_b0));
      cyc();
      in_a0 = 10'($urandom); in_b0 = 10'($urandom);
    end
    checks++;
    if (delivered !== 6 || ops_done !== 16'd6) begin
      failures++; $display("FAIL b2b_count delivered=%0d ops=%0d want 6 6", delivered, ops_done);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    out_ready0 = 1;
    in_a0 = 10'd77; in_b0 = 10'd5; in_valid0 = 1; #1;
    cyc(); in_valid0 = 0; #1;
    checks++;
    if (busy !== 1'b1 || mul_a !== 10'd77) begin failures++; $display("FAIL rmid_busy busy=%b a=%0d want 1 77", busy, mul_a); end
    rst_n = 0; in_valid0 = 1; #1;
    checks++;
    if ({mul_a, mul_b, out_valid0, out_valid1, busy, ops_done, in_ready0, in_ready1} !== '0) begin
      failures++; $display("FAIL rmid_clear a=%0d ov=%b%b busy=%b ops=%0d rdy=%b%b want all zero",
                           mul_a, out_valid0, out_valid1, busy, ops_done, in_ready0, in_ready1);
    end
    in_valid0 = 0;
    cyc(); rst_n = 1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      #1; if (out_valid0 || out_valid1) seen++;
      cyc();
    end
    checks++;
    if (seen !== 0 || ops_done !== 16'd0) begin
      failures++; $display("FAIL rmid_after ov_cycles=%0d ops=%0d want 0 0", seen, ops_done);
    end
  endtask

  task automatic test_random();
    logic mv, mid;
    logic [OP_W-1:0] ma, mb;
    logic [1:0] m_ov;
    logic [P_W-1:0] m_p [2];
    logic [15:0] m_ops;
    logic m_prio;
    logic e0, e1, w0, w1, g0, g1, tie;
    do_reset();
    mv = 0; mid = 0; ma = 0; mb = 0; m_ov = 0; m_p[0] = 0; m_p[1] = 0; m_ops = 0; m_prio = 0;
    for (int c = 0; c < 1500; c++) begin
      in_valid0 = ($urandom_range(0, 2) != 0); in_valid1 = ($urandom_range(0, 2) != 0);
      out_ready0 = ($urandom_range(0, 3) != 0); out_ready1 = ($urandom_range(0, 3) != 0);
      in_a0 = 10'($urandom); in_b0 = 10'($urandom); in_a1 = 10'($urandom); in_b1 = 10'($urandom);
      #1;
      checks++;
      if (out_valid0 !== m_ov[0] || out_valid1 !== m_ov[1] || (m_ov[0] && out_p0 !== m_p[0]) ||
          (m_ov[1] && out_p1 !== m_p[1]) || ops_done !== m_ops || busy !== (mv | m_ov[0] | m_ov[1]) ||
          (mv && (mul_a !== ma || mul_b !== mb))) begin
        failures++; $display("FAIL rand_out c=%0d ov=%b%b p0=%0d p1=%0d ops=%0d busy=%b want ov=%b%b p0=%0d p1=%0d ops=%0d",
                             c, out_valid1, out_valid0, out_p0, out_p1, ops_done, busy, m_ov[1], m_ov[0], m_p[0], m_p[1], m_ops);
      end
      e0 = !((mv && mid == 0) || (m_ov[0] && !out_ready0));
      e1 = !((mv && mid == 1) || (m_ov[1] && !out_ready1));
      w0 = e0 && in_valid0; w1 = e1 && in_valid1;
`ifdef MUL_SCHED_RR_EN
      tie = m_prio;
`else
      tie = 0;
`endif
      g0 = w0 && !(w1 && tie == 1);
      g1 = w1 && !(w0 && tie == 0);
      checks++;
      if ({in_ready1, in_ready0} !== {g1, g0}) begin
        failures++; $display("FAIL rand_grant c=%0d got=%b%b want=%b%b", c, in_ready1, in_ready0, g1, g0);
      end
      m_ops = m_ops + 16'(m_ov[0] && out_ready0) + 16'(m_ov[1] && out_ready1);
      for (int i = 0; i < 2; i++) begin
        if (mv && mid == i) begin m_ov[i] = 1; m_p[i] = P_W'(ma) * P_W'(mb); end
        else if (m_ov[i] && (i == 0 ? out_ready0 : out_ready1)) m_ov[i] = 0;
      end
      mv = g0 | g1;
      if (g0) begin mid = 0; ma = in_a0; mb = in_b0; m_prio = 1; end
      if (g1) begin mid = 1; ma = in_a1; mb = in_b1; m_prio = 0; end
      cyc();
    end
    in_valid0 = 0; in_valid1 = 0; out_ready0 = 1; out_ready1 = 1;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_wrap();
    int acc, n;
    do_reset();
    out_ready0 = 1; out_ready1 = 1;
    in_a0 = 10'd3; in_b0 = 10'd4; in_a1 = 10'd5; in_b1 = 10'd6;
    acc = 0; n = 0;
    while (acc < 65535 && n < 70000) begin
      in_valid0 = 1; in_valid1 = 1;
      #1;
      if (in_ready0 || in_ready1) acc++;
      cyc();
      n++;
    end
    in_valid0 = 0; in_valid1 = 0;
    checks++;
    if (acc !== 65535) begin failures++; $display("FAIL wrap_timeout accepted=%0d want=65535", acc); end
    cyc(); cyc(); cyc(); #1;
    checks++;
    if (ops_done !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h want=ffff", ops_done); end
    in_valid0 = 1; #1; cyc(); in_valid0 = 0;
    cyc(); cyc(); cyc(); #1;
    checks++;
    if (ops_done !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h want=0000", ops_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
